// File: rtl/fetch_pc_if.sv
// Fetch address handshake between the PC generator and its consumer.
// master: drives pc_out/pc_valid, samples pc_ready; slave: the reverse.
interface fetch_pc_if #(
    parameter int unsigned PC_W = 8
) ();
    logic [PC_W-1:0] pc_out;
    logic            pc_valid;
    logic            pc_ready;

    modport master (
        output pc_out,
        output pc_valid,
        input  pc_ready
    );

    modport slave (
        input  pc_out,
        input  pc_valid,
        output pc_ready
    );
endinterface

// File: rtl/fetch_pc.sv
// Program counter generator: offers fetch addresses with valid/ready,
// redirects on branch, stops on halt. Ports: clk, reset (async low), en,
// br_valid/br_target, halt, halted, pc_if (pc_out/pc_valid/pc_ready).
module fetch_pc #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned STEP     = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    input  logic            halt,
    output logic            halted,
    fetch_pc_if.master      pc_if
);

    localparam logic [PC_W-1:0] RST_V  = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic            xfer;

    // The offer is masked by en so a frozen block never hands out an address.
    assign pc_if.pc_valid = valid_q & en;
    assign pc_if.pc_out   = pc_q;
    assign halted         = halted_q;
    assign xfer           = pc_if.pc_valid & pc_if.pc_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RST_V;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                S_IDLE: state_d = S_RUN;
                S_RUN: begin
                    if (!br_valid && halt) begin
                        state_d = S_HALT;
                    end
                end
                S_HALT: begin
                    if (br_valid) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Branch beats halt beats transfer; a halting transfer still completes
    // downstream but the address is not advanced past it.
    always_comb begin
        pc_d     = pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        if (en) begin
            unique case (state_q)
                S_IDLE: begin
                    pc_d     = RST_V;
                    valid_d  = 1'b1;
                    halted_d = 1'b0;
                end
                S_RUN: begin
                    if (br_valid) begin
                        pc_d    = br_target;
                        valid_d = 1'b1;
                    end else if (halt) begin
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                    end else if (xfer) begin
                        pc_d = pc_q + STEP_V;
                    end
                end
                S_HALT: begin
                    if (br_valid) begin
                        pc_d     = br_target;
                        valid_d  = 1'b1;
                        halted_d = 1'b0;
                    end
                end
                default: begin
                    pc_d     = RST_V;
                    valid_d  = 1'b0;
                    halted_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed scenarios then random traffic
// compared against a behavioural model of the fetch address stream.
module tb_fetch_pc;

    logic       clk;
    logic       reset;
    logic       en;
    logic       br_valid;
    logic [7:0] br_target;
    logic       halt;
    logic       halted;

    fetch_pc_if #(.PC_W(8)) pc_if ();

    fetch_pc #(
        .PC_W    (8),
        .RESET_PC(0),
        .STEP    (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .br_valid (br_valid),
        .br_target(br_target),
        .halt     (halt),
        .halted   (halted),
        .pc_if    (pc_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: started/stopped flags, offered flag, address as plain integer.
    bit m_started;
    bit m_stopped;
    bit m_offer;
    int m_pc;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_stopped = 0;
        m_offer   = 0;
        m_pc      = 0;
    endtask

    task automatic check_model(string tag);
        chk({tag, ".pc"}, 32'(pc_if.pc_out), 32'(m_pc));
        chk({tag, ".valid"}, 32'(pc_if.pc_valid), 32'(m_offer && en));
        chk({tag, ".halted"}, 32'(halted), 32'(m_stopped));
    endtask

    // Called at a negedge with inputs already set; returns at next negedge.
    task automatic cycle(string tag);
        bit n_started, n_stopped, n_offer;
        int n_pc;
        #1;
        check_model(tag);
        n_started = m_started;
        n_stopped = m_stopped;
        n_offer   = m_offer;
        n_pc      = m_pc;
        if (en) begin
            if (!m_started && !m_stopped) begin
                n_started = 1;
                n_offer   = 1;
                n_pc      = 0;
            end else if (m_stopped) begin
                if (br_valid) begin
                    n_stopped = 0;
                    n_started = 1;
                    n_offer   = 1;
                    n_pc      = br_target;
                end
            end else if (br_valid) begin
                n_offer = 1;
                n_pc    = br_target;
            end else if (halt) begin
                n_started = 0;
                n_stopped = 1;
                n_offer   = 0;
            end else if (m_offer && pc_if.pc_ready) begin
                n_pc = (m_pc + 1) % 256;
            end
        end
        @(posedge clk);
        m_started = n_started;
        m_stopped = n_stopped;
        m_offer   = n_offer;
        m_pc      = n_pc;
        @(negedge clk);
    endtask

    task automatic async_reset(string tag);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        chk({tag, ".pc"}, 32'(pc_if.pc_out), 32'h0);
        chk({tag, ".valid"}, 32'(pc_if.pc_valid), 32'h0);
        chk({tag, ".halted"}, 32'(halted), 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_in(bit e, bit b, int t, bit h, bit r);
        en             = e;
        br_valid       = b;
        br_target      = 8'(t);
        halt           = h;
        pc_if.pc_ready = r;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("rst.pc", 32'(pc_if.pc_out), 32'h0);
        chk("rst.valid", 32'(pc_if.pc_valid), 32'h0);
        chk("rst.halted", 32'(halted), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Idle holds with en low, ignores branch/halt when started.
        set_in(0, 1, 8'h55, 1, 1);
        cycle("idle_en0");
        cycle("idle_en0b");
        set_in(1, 1, 8'h55, 1, 1);
        cycle("start");
        #1;
        chk("start.pc", 32'(pc_if.pc_out), 32'h0);
        chk("start.valid", 32'(pc_if.pc_valid), 32'h1);
        set_in(1, 0, 0, 0, 1);
        for (int k = 1; k <= 5; k++) begin
            cycle("seq");
            chk("seq.pc", 32'(pc_if.pc_out), 32'(k));
        end

        // Backpressure at 5.
        set_in(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle("bp");
        #1;
        chk("bp.pc", 32'(pc_if.pc_out), 32'h5);
        chk("bp.valid", 32'(pc_if.pc_valid), 32'h1);
        set_in(1, 0, 0, 0, 1);
        cycle("bp_rel");
        chk("bp_rel.pc", 32'(pc_if.pc_out), 32'h6);
        cycle("to7");

        // Halt at 7 without acceptance, then restart by branch.
        set_in(1, 0, 0, 1, 0);
        cycle("halt");
        chk("halt.valid", 32'(pc_if.pc_valid), 32'h0);
        chk("halt.halted", 32'(halted), 32'h1);
        chk("halt.pc", 32'(pc_if.pc_out), 32'h7);
        set_in(1, 0, 0, 1, 1);
        cycle("halt_hold");
        set_in(1, 1, 8'h10, 0, 0);
        cycle("restart");
        chk("restart.pc", 32'(pc_if.pc_out), 32'h10);
        chk("restart.valid", 32'(pc_if.pc_valid), 32'h1);

        // Branch wins over halt.
        set_in(1, 1, 8'h40, 1, 1);
        cycle("br_halt");
        chk("br_halt.pc", 32'(pc_if.pc_out), 32'h40);
        chk("br_halt.halted", 32'(halted), 32'h0);

        // Wrap with enable gap.
        set_in(1, 1, 8'hFF, 0, 0);
        cycle("to_ff");
        set_in(0, 0, 0, 0, 1);
        cycle("en0a");
        cycle("en0b");
        #1;
        chk("en0.valid", 32'(pc_if.pc_valid), 32'h0);
        chk("en0.pc", 32'(pc_if.pc_out), 32'hFF);
        set_in(1, 0, 0, 0, 1);
        cycle("wrap");
        chk("wrap.pc", 32'(pc_if.pc_out), 32'h0);

        // Async reset mid-run at 0x22.
        set_in(1, 1, 8'h22, 0, 0);
        cycle("to_22");
        async_reset("arst");
        set_in(0, 0, 0, 0, 0);
        cycle("post_rst");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                async_reset("rnd_rst");
            end
            set_in($urandom_range(9) != 0,
                   $urandom_range(7) == 0,
                   int'($urandom_range(255)),
                   $urandom_range(9) == 0,
                   $urandom_range(1) == 1);
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter PC_W, default 8, program counter width in bits.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Parameter STEP, default 1, PC increment per accepted fetch.
REQ-004 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-low reset.
REQ-006 Port en, input, 1, global enable; low freezes all state.
REQ-007 Port br_valid, input, 1, redirect request, sampled on the rising edge.
REQ-008 Port br_target, input, PC_W, redirect address, qualified by br_valid.
REQ-009 Port halt, input, 1, stop-fetch request, sampled on the rising edge.
REQ-010 Port pc_ready, input, 1, downstream accepts pc_out this cycle.
REQ-011 Port pc_out, output, PC_W, current fetch address, registered.
REQ-012 Port pc_valid, output, 1, pc_out offered to downstream.
REQ-013 Port halted, output, 1, high while in state HALT, registered.

Function
REQ-014 The block SHALL implement three states: IDLE, RUN and HALT.
REQ-015 Internal valid_r SHALL be registered; pc_valid SHALL equal valid_r AND en, combinationally.
REQ-016 Transfer SHALL be defined as pc_valid AND pc_ready in the same cycle.
REQ-017 With en low, state, pc_out, valid_r and halted SHALL hold, and all other inputs SHALL be ignored.
REQ-018 In IDLE with en high, the next state SHALL be RUN with valid_r=1 and pc_out=RESET_PC, so the first offer appears one cycle after en is first sampled high.
REQ-019 In IDLE, br_valid and halt SHALL be ignored.
REQ-020 In RUN, priority SHALL be: br_valid, then halt, then transfer.
REQ-021 RUN with br_valid: next pc_out=br_target, valid_r=1, regardless of pc_ready; a same-cycle transfer of the old pc_out completes normally.
REQ-022 RUN with halt and no br_valid: next state HALT, valid_r=0, halted=1, pc_out held; an unaccepted offer is retracted; a same-cycle transfer completes but pc_out does not advance.
REQ-023 RUN with transfer and no br_valid/halt: next pc_out=(pc_out+STEP) mod 2^PC_W, valid_r stays 1.
REQ-024 RUN without transfer, br_valid or halt: pc_out and valid_r SHALL hold, so an offer stays stable until accepted.
REQ-025 PC arithmetic SHALL wrap silently, e.g. 8'hFF+1 -> 8'h00; no overflow flag.
REQ-026 In HALT, halt SHALL be ignored; br_valid SHALL give next state RUN, pc_out=br_target, valid_r=1, halted=0.
REQ-027 pc_out SHALL change only on a clock edge with en high, or on reset.

Reset
REQ-028 While reset is low, outputs SHALL immediately be pc_out=RESET_PC, valid_r=0 (pc_valid=0), halted=0, and state SHALL be IDLE, independent of clk.
REQ-029 Reset asserted mid-operation (RUN or HALT) SHALL abort any pending offer with no further transfer.
REQ-030 After reset deasserts, the block SHALL remain in IDLE until en is sampled high.

Verification
REQ-031 Startup: reset low then high, en=1, pc_ready=1 -> pc_valid rises 1 cycle after en; pc_out sequence 0,1,2,3 on successive cycles.
REQ-032 Backpressure: pc_out=5, pc_valid=1, pc_ready=0 for 3 cycles -> pc_out stays 5, pc_valid stays 1; pc_ready=1 -> next cycle pc_out=6.
REQ-033 Branch vs halt: br_valid=1, br_target=8'h40, halt=1 in the same RUN cycle -> next pc_out=8'h40, pc_valid=1, halted=0.
REQ-034 Halt and restart: halt=1 at pc_out=7 with pc_ready=0 -> pc_valid=0, halted=1, pc_out=7; br_valid=1, br_target=8'h10 -> RUN, pc_out=8'h10, pc_valid=1.
REQ-035 Wrap and enable: pc_out=8'hFF, pc_ready=1, en=0 for 2 cycles -> pc_valid=0, pc_out=8'hFF; en=1 -> next pc_out=8'h00.
REQ-036 Async reset: reset low between clock edges while in RUN at pc_out=8'h22 -> immediately pc_out=0, pc_valid=0, halted=0.
